ysyx_23060077_riscv_mem_arbiter: RTL and testbench

//  Shares the single physical memory port between the IFU (inst fetch) and the LSU (load/store).

---
 rtl/ysyx_23060077_riscv_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_23060077_riscv_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060077_riscv_mem_arbiter
//  Purpose  : Shares one memory port between the instruction fetch unit (IFU)
//             and the load/store unit (LSU). One transaction is in flight at
//             a time: IDLE -> REQ -> WAIT -> RESP -> IDLE. Conflicting
//             requests are granted round-robin, and a watchdog closes a hung
//             transaction with an error response.
//  Ports    :
//    clk, rst_n                    clock, asynchronous active-low reset
//    ifu_req_valid_i/ready_o       IFU request handshake, ifu_addr_i = pc
//    ifu_resp_valid_o              1-cycle pulse, ifu_rdata_o/ifu_resp_err_o
//    lsu_req_valid_i/ready_o       LSU request handshake
//    lsu_addr_i/wen_i/wdata_i/wmask_i   LSU request fields
//    lsu_resp_valid_o              1-cycle pulse, lsu_rdata_o/lsu_resp_err_o
//    mem_req_valid_o/ready_i       memory request handshake
//    mem_addr_o/wen_o/wdata_o/wmask_o   registered memory request fields
//    mem_resp_valid_i/mem_rdata_i  memory response (1 cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060077_riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU side
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_resp_valid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_resp_err_o,
  // LSU side
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_resp_valid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_resp_err_o,
  // Memory side
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int MASK_W = DATA_W / 8;
  // Last WAIT cycle index: the transaction times out once TIMEOUT cycles
  // have been spent in WAIT without a response.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic                last_lsu_q,  last_lsu_d;   // 1: last grant went to LSU
  logic                owner_lsu_q, owner_lsu_d;  // 1: in-flight txn is LSU's
  logic [7:0]          cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic                wen_q,       wen_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [MASK_W-1:0]   wmask_q,     wmask_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                err_q,       err_d;

  logic pick_lsu;
  logic accept;
  logic resp_ifu;
  logic resp_lsu;

  // LSU wins when it is the sole requester, or on a conflict when the IFU
  // held the previous grant (reset value of last_lsu_q makes the first
  // conflict go to the LSU).
  assign pick_lsu = lsu_req_valid_i & (~ifu_req_valid_i | ~last_lsu_q);
  assign accept   = (state_q == S_IDLE) & (ifu_req_valid_i | lsu_req_valid_i);

  // Ready is gated by rst_n so every output is quiet while reset is held.
  assign lsu_req_ready_o = rst_n & accept & pick_lsu;
  assign ifu_req_ready_o = rst_n & accept & ~pick_lsu;

  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    owner_lsu_d = owner_lsu_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_REQ;
          owner_lsu_d = pick_lsu;
          last_lsu_d  = pick_lsu;
          if (pick_lsu) begin
            addr_d  = lsu_addr_i;
            wen_d   = lsu_wen_i;
            wdata_d = lsu_wdata_i;
            wmask_d = lsu_wmask_i;
          end else begin
            // Fetches are always full-word reads.
            addr_d  = ifu_addr_i;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '1;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving in the final cycle still beats the timeout.
        if (mem_resp_valid_i) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          if (owner_lsu_q) lsu_rdata_d = mem_rdata_i;
          else             ifu_rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (owner_lsu_q) lsu_rdata_d = '0;
          else             ifu_rdata_d = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_lsu_q  <= last_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  assign resp_ifu = (state_q == S_RESP) & ~owner_lsu_q;
  assign resp_lsu = (state_q == S_RESP) &  owner_lsu_q;

  assign mem_req_valid_o  = (state_q == S_REQ);
  assign mem_addr_o       = addr_q;
  assign mem_wen_o        = wen_q;
  assign mem_wdata_o      = wdata_q;
  assign mem_wmask_o      = wmask_q;

  assign ifu_resp_valid_o = resp_ifu;
  assign ifu_rdata_o      = ifu_rdata_q;
  assign ifu_resp_err_o   = resp_ifu & err_q;
  assign lsu_resp_valid_o = resp_lsu;
  assign lsu_rdata_o      = lsu_rdata_q;
  assign lsu_resp_err_o   = resp_lsu & err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060077_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060077_riscv_mem_arbiter
//  Purpose  : Directed scoreboard bench for the IFU/LSU memory arbiter.
//             Stimulus pushes the expected memory requests and responses;
//             a monitor pops and compares whenever the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060077_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  ysyx_23060077_riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_valid_i  (ifu_req_valid),
    .ifu_req_ready_o  (ifu_req_ready),
    .ifu_addr_i       (ifu_addr),
    .ifu_resp_valid_o (ifu_resp_valid),
    .ifu_rdata_o      (ifu_rdata),
    .ifu_resp_err_o   (ifu_resp_err),
    .lsu_req_valid_i  (lsu_req_valid),
    .lsu_req_ready_o  (lsu_req_ready),
    .lsu_addr_i       (lsu_addr),
    .lsu_wen_i        (lsu_wen),
    .lsu_wdata_i      (lsu_wdata),
    .lsu_wmask_i      (lsu_wmask),
    .lsu_resp_valid_o (lsu_resp_valid),
    .lsu_rdata_o      (lsu_rdata),
    .lsu_resp_err_o   (lsu_resp_err),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_addr_o       (mem_addr),
    .mem_wen_o        (mem_wen),
    .mem_wdata_o      (mem_wdata),
    .mem_wmask_o      (mem_wmask),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_rdata_i      (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          lsu;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic mreq_t mk_req(input logic lsu, input logic [AW-1:0] a, input logic w,
                                   input logic [DW-1:0] d, input logic [MW-1:0] m);
    mreq_t r;
    r.addr  = a;
    r.wen   = lsu ? w : 1'b0;
    r.wdata = d;
    r.wmask = lsu ? m : 4'hF;
    return r;
  endfunction

  task automatic push_resp(input logic lsu, input logic [DW-1:0] d, input logic e);
    resp_t r;
    r.lsu = lsu; r.rdata = d; r.err = e;
    resp_q.push_back(r);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    resp_t r;
    mreq_t m;
    if (rst_n === 1'b1) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_side", {62'd0, ifu_resp_valid, lsu_resp_valid}, r.lsu ? 64'd1 : 64'd2);
          chk("resp_rdata", r.lsu ? lsu_rdata : ifu_rdata, {32'd0, r.rdata});
          chk("resp_err", r.lsu ? lsu_resp_err : ifu_resp_err, {63'd0, r.err});
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mreq_q.size() == 0) begin
          chk("mreq_unexpected", {63'd0, mem_req_valid}, 64'd0);
        end else begin
          m = mreq_q.pop_front();
          chk("mreq_addr", mem_addr, {32'd0, m.addr});
          chk("mreq_wen_mask", {59'd0, mem_wen, mem_wmask}, {59'd0, m.wen, m.wmask});
          if (m.wen) chk("mreq_wdata", mem_wdata, {32'd0, m.wdata});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic all_zero(input string name);
    chk(name, {55'd0, ifu_req_ready, ifu_resp_valid, ifu_resp_err, lsu_req_ready,
               lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen, |mem_wmask}, 64'd0);
    chk({name, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
    chk({name, "_memfld"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  // Single requester from IDLE; called #1 after a posedge.
  task automatic issue(input logic lsu, input mreq_t e);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = e.addr; lsu_wen = e.wen;
      lsu_wdata = e.wdata; lsu_wmask = e.wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = e.addr;
    end
    @(negedge clk);
    chk("ready_winner", lsu ? lsu_req_ready : ifu_req_ready, 64'd1);
    chk("ready_other",  lsu ? ifu_req_ready : lsu_req_ready, 64'd0);
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk("req_latency", {63'd0, mem_req_valid}, 64'd1);
  endtask

  // Memory model: hold off bp cycles, accept, spend wcyc cycles in WAIT,
  // then optionally return rdata. Returns #1 after the edge entering RESP.
  task automatic mem_serve(input int bp, input int wcyc, input bit give_resp,
                           input logic [DW-1:0] rdata, input mreq_t e);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("mreq_seen", {63'd0, mem_req_valid}, 64'd1);
    if (mem_req_valid !== 1'b1) return;
    for (int i = 0; i < bp; i++) begin
      cyc(1);
      chk("bp_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("bp_addr", mem_addr, {32'd0, e.addr});
      chk("bp_ctl", {59'd0, mem_wen, mem_wmask}, {59'd0, e.wen, e.wmask});
      if (e.wen) chk("bp_wdata", mem_wdata, {32'd0, e.wdata});
    end
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready = 1'b0;
    for (int i = 0; i < wcyc; i++) begin
      chk("wait_no_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      cyc(1);
    end
    if (give_resp) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      cyc(1);
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h5555_AAAA;
    end
    chk("resp_latency", {63'd0, ifu_resp_valid | lsu_resp_valid}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=hung required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mreq_t e;
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state, even with requests pending.
    cyc(3);
    all_zero("reset_state");
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    // Conflict: both valid for 4 transactions -> LSU, IFU, LSU, IFU.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    @(negedge clk);
    chk("conflict_first_lsu", {62'd0, lsu_req_ready, ifu_req_ready}, 64'd2);
    for (int k = 0; k < 4; k++) begin
      logic l;
      l = (k % 2 == 0);
      e = mk_req(l, l ? 32'h8000_2000 : 32'h8000_0100, 1'b0, '0, 4'hF);
      mreq_q.push_back(e);
      push_resp(l, 32'h1000_0000 + k, 1'b0);
      mem_serve(0, 1, 1'b1, 32'h1000_0000 + k, e);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    cyc(1);

    // IFU fetch.
    e = mk_req(1'b0, 32'h8000_0000, 1'b0, '0, 4'hF);
    mreq_q.push_back(e);
    push_resp(1'b0, 32'h0000_0413, 1'b0);
    issue(1'b0, e);
    mem_serve(0, 2, 1'b1, 32'h0000_0413, e);
    cyc(1);

    // LSU store, partial mask.
    e = mk_req(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    mreq_q.push_back(e);
    push_resp(1'b1, 32'h0000_0000, 1'b0);
    issue(1'b1, e);
    mem_serve(0, 0, 1'b1, 32'h0000_0000, e);
    cyc(1);

    // LSU load with one backpressure cycle.
    e = mk_req(1'b1, 32'h8000_2004, 1'b0, 32'h0, 4'hF);
    mreq_q.push_back(e);
    push_resp(1'b1, 32'h1234_5678, 1'b0);
    issue(1'b1, e);
    mem_serve(1, 3, 1'b1, 32'h1234_5678, e);
    cyc(1);

    // Backpressure: memory not ready for 5 cycles, store fields held.
    e = mk_req(1'b1, 32'h8000_3008, 1'b1, 32'hA5A5_0F0F, 4'b1100);
    mreq_q.push_back(e);
    push_resp(1'b1, 32'h0000_0000, 1'b0);
    issue(1'b1, e);
    mem_serve(5, 1, 1'b1, 32'h0000_0000, e);
    cyc(1);

    // Timeout: no response for TIMEOUT cycles in WAIT.
    e = mk_req(1'b1, 32'h8000_4000, 1'b0, '0, 4'hF);
    mreq_q.push_back(e);
    push_resp(1'b1, 32'h0000_0000, 1'b1);
    issue(1'b1, e);
    mem_serve(0, TO, 1'b0, '0, e);
    cyc(1);

    // Response in the final WAIT cycle beats the timeout.
    e = mk_req(1'b0, 32'h8000_0004, 1'b0, '0, 4'hF);
    mreq_q.push_back(e);
    push_resp(1'b0, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, e);
    mem_serve(0, TO - 1, 1'b1, 32'hCAFE_F00D, e);
    cyc(1);

    // Reset in the middle of WAIT: abandoned, outputs cleared at once.
    e = mk_req(1'b0, 32'h8000_0040, 1'b0, '0, 4'hF);
    mreq_q.push_back(e);
    issue(1'b0, e);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    #1;
    all_zero("reset_midwait");
    cyc(2);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    cyc(1);
    mem_resp_valid = 1'b0;
    chk("stale_resp_ignored", {61'd0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'd0);
    cyc(1);
    chk("stale_resp_quiet", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);

    // Normal operation resumes after reset.
    e = mk_req(1'b0, 32'h8000_0080, 1'b0, '0, 4'hF);
    mreq_q.push_back(e);
    push_resp(1'b0, 32'h0010_0093, 1'b0);
    issue(1'b0, e);
    mem_serve(0, 0, 1'b1, 32'h0010_0093, e);
    cyc(2);

    @(negedge clk);
    chk("sb_resp_drain", resp_q.size(), 64'd0);
    chk("sb_mreq_drain", mreq_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
